// File: rtl/bus_arbiter4.sv
// Round-robin owner selection for the 4-requester shared byte bus. Grant is registered one cycle after req.
// Owner changes always pass through one idle TURN cycle. Requesters are never backpressured; they hold req.
module bus_arbiter4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       bus_en,
  output logic       preempt
);

  localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [1:0]      sel_q, sel_d;
  logic            bus_en_q, bus_en_d;
  logic            preempt_q, preempt_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [HW-1:0]   hold_q, hold_d;

  logic            win_vld;
  logic [1:0]      win_idx;
  logic            others;

  // First requester at or after ptr, wrapping modulo 4.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (!win_vld && req[ptr_q + 2'(k)]) begin
        win_vld = 1'b1;
        win_idx = ptr_q + 2'(k);
      end
    end
  end

  assign others = |(req & ~gnt_q);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    case (state_q)
      IDLE, TURN: begin
        if (win_vld) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win_idx;
          sel_d   = win_idx;
          hold_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + HW'(1);
        // Release wins over preemption when both hold in the same cycle.
        if (!req[sel_q]) begin
          state_d = TURN;
          gnt_d   = '0;
          ptr_d   = sel_q + 2'd1;
        end else if (hold_q == HOLD_LAST && others) begin
          state_d   = TURN;
          gnt_d     = '0;
          ptr_d     = sel_q + 2'd1;
          preempt_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    bus_en_d = |gnt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      sel_q     <= '0;
      bus_en_q  <= 1'b0;
      preempt_q <= 1'b0;
      ptr_q     <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      bus_en_q  <= bus_en_d;
      preempt_q <= preempt_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign bus_en  = bus_en_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_bus_arbiter4.sv
// Bench for bus_arbiter4: directed vector table through a scoreboard queue, then random req with per-cycle invariants.
module tb_bus_arbiter4;

  localparam int MAX_HOLD   = 8;
  localparam int WAIT_BOUND = 4 * (MAX_HOLD + 1);

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       bus_en;
  logic       preempt;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       pre;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];

  int   n_chk  = 0;
  int   n_pass = 0;
  logic chk_en = 1'b0;
  logic [3:0] prev_gnt = 4'b0000;
  int   wait_cnt[4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  bus_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .bus_en  (bus_en),
    .preempt (preempt)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic void add(input logic r, input logic [3:0] q, input logic [3:0] g,
                              input logic [1:0] s, input logic p);
    vec_t v;
    v.rst = r;
    v.req = q;
    v.gnt = g;
    v.sel = s;
    v.pre = p;
    vecs.push_back(v);
  endfunction

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    rst = v.rst;
    req = v.req;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check($sformatf("vec%0d gnt/sel/bus_en/preempt", idx),
          16'({gnt, sel, bus_en, preempt}),
          16'({e.gnt, e.sel, |e.gnt, e.pre}));
  endtask

  // Per-cycle invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("onehot0", 16'($onehot0(gnt)), 16'd1);
      check("bus_en", 16'(bus_en), 16'(|gnt));
      if (bus_en) check("sel_match", 16'(gnt), 16'(4'b0001 << sel));
      if (preempt) check("preempt_in_turn", 16'(gnt), 16'd0);
      if (prev_gnt != 4'b0000 && gnt != 4'b0000) check("turnaround", 16'(gnt), 16'(prev_gnt));
      prev_gnt = gnt;
      for (int i = 0; i < 4; i++) begin
        if (req[i] && !gnt[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > WAIT_BOUND) check($sformatf("starve%0d", i), 16'(wait_cnt[i]), 16'(WAIT_BOUND));
      end
    end
  end

  initial begin
    rst = 1'b1;
    req = 4'b0000;

    // Reset, single requester 2, release, ptr now 3.
    add(1, 4'b0000, 4'b0000, 2'd0, 0);
    add(1, 4'b0000, 4'b0000, 2'd0, 0);
    add(0, 4'b0000, 4'b0000, 2'd0, 0);
    add(0, 4'b0100, 4'b0100, 2'd2, 0);
    add(0, 4'b0100, 4'b0100, 2'd2, 0);
    add(0, 4'b0100, 4'b0100, 2'd2, 0);
    add(0, 4'b0000, 4'b0000, 2'd2, 0);
    add(0, 4'b0000, 4'b0000, 2'd2, 0);
    add(0, 4'b1001, 4'b1000, 2'd3, 0);
    add(0, 4'b0000, 4'b0000, 2'd3, 0);
    add(0, 4'b0000, 4'b0000, 2'd3, 0);

    // Owner 1 releases exactly when hold reaches its limit with req[3] waiting.
    add(0, 4'b1010, 4'b0010, 2'd1, 0);
    for (int k = 0; k < 7; k++) add(0, 4'b1010, 4'b0010, 2'd1, 0);
    add(0, 4'b1000, 4'b0000, 2'd1, 0);
    add(0, 4'b1000, 4'b1000, 2'd3, 0);
    add(0, 4'b0000, 4'b0000, 2'd3, 0);
    add(0, 4'b0000, 4'b0000, 2'd3, 0);

    // Back-to-back grant out of TURN, then reset mid-grant restores ptr=0.
    add(0, 4'b0100, 4'b0100, 2'd2, 0);
    add(0, 4'b0000, 4'b0000, 2'd2, 0);
    add(0, 4'b0010, 4'b0010, 2'd1, 0);
    add(0, 4'b0010, 4'b0010, 2'd1, 0);
    add(1, 4'b0010, 4'b0000, 2'd0, 0);
    add(0, 4'b1010, 4'b0010, 2'd1, 0);
    add(0, 4'b0000, 4'b0000, 2'd1, 0);
    add(0, 4'b0000, 4'b0000, 2'd1, 0);
    add(1, 4'b0000, 4'b0000, 2'd0, 0);

    // All four requesting: rotation 0,1,2,3,0 with MAX_HOLD grant cycles then a preempting TURN.
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < MAX_HOLD; k++) add(0, 4'b1111, 4'b0001 << (r % 4), 2'(r % 4), 0);
      add(0, 4'b1111, 4'b0000, 2'(r % 4), 1);
    end
    add(0, 4'b0000, 4'b0000, 2'd0, 0);

    // Lone owner keeps the bus past the hold limit; preempted as soon as req[2] appears.
    for (int k = 0; k < 40; k++) add(0, 4'b0001, 4'b0001, 2'd0, 0);
    add(0, 4'b0101, 4'b0000, 2'd0, 1);
    add(0, 4'b0101, 4'b0100, 2'd2, 0);
    add(0, 4'b0000, 4'b0000, 2'd2, 0);
    add(0, 4'b0000, 4'b0000, 2'd2, 0);

    // Re-grant of the same requester still takes one TURN cycle.
    add(0, 4'b0100, 4'b0100, 2'd2, 0);
    add(0, 4'b0000, 4'b0000, 2'd2, 0);
    add(0, 4'b0100, 4'b0100, 2'd2, 0);
    add(0, 4'b0000, 4'b0000, 2'd2, 0);
    add(0, 4'b0000, 4'b0000, 2'd2, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
      if (i == 0) chk_en = 1'b1;
    end

    // Random requests with persistence so both release and preemption paths occur.
    rst = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      logic [3:0] flip;
      for (int i = 0; i < 4; i++) flip[i] = ($urandom_range(0, 7) == 0);
      req = req ^ flip;
      @(posedge clk);
      #1;
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
